// File: rtl/pipe_mem_pkg.sv
// Shared types and limits for the IF/MEM memory-port arbiter.
package pipe_mem_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned LAT_MAX = 15;
  localparam int unsigned DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    BUSY_IF  = 2'b01,
    BUSY_MEM = 2'b10
  } state_t;

endpackage

// File: rtl/pipe_mem_arb_if.sv
// Pipeline-side request/response signals plus the single-port memory bus.
interface pipe_mem_arb_if;
  import pipe_mem_pkg::*;

  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              ram_en;
  logic              ram_we;
  logic [DATA_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              stall_if;
  logic              stall_mem;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready,
           ram_en, ram_we, ram_addr, ram_wdata, stall_if, stall_mem
  );

  // Pipeline and memory side
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
           ram_en, ram_we, ram_addr, ram_wdata, stall_if, stall_mem
  );

endinterface

// File: rtl/pipe_mem_arb.sv
// Shares one single-port memory between IF and MEM with fixed wait states;
// MEM has priority, accesses are never preempted.
module pipe_mem_arb
  import pipe_mem_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic           clock,
  input  logic           resetn,
  pipe_mem_arb_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              lat_we, lat_we_n;
  logic              ram_en_q, ram_en_n;
  logic              ram_we_q, ram_we_n;
  logic [DATA_W-1:0] ram_addr_q, ram_addr_n;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_n;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_n;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_n;
  logic              if_ready_q, if_ready_n;
  logic              mem_ready_q, mem_ready_n;
  logic              if_elig, mem_elig;

  // A requester in its ready cycle still holds req high but must not re-win.
  assign if_elig  = bus.if_req  & ~if_ready_q;
  assign mem_elig = bus.mem_req & ~mem_ready_q;

  assign bus.stall_if  = if_elig;
  assign bus.stall_mem = mem_elig;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_we      <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      lat_we      <= lat_we_n;
      ram_en_q    <= ram_en_n;
      ram_we_q    <= ram_we_n;
      ram_addr_q  <= ram_addr_n;
      ram_wdata_q <= ram_wdata_n;
      if_rdata_q  <= if_rdata_n;
      mem_rdata_q <= mem_rdata_n;
      if_ready_q  <= if_ready_n;
      mem_ready_q <= mem_ready_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    lat_we_n    = lat_we;
    ram_en_n    = ram_en_q;
    ram_we_n    = 1'b0;
    ram_addr_n  = ram_addr_q;
    ram_wdata_n = ram_wdata_q;
    if_rdata_n  = if_rdata_q;
    mem_rdata_n = mem_rdata_q;
    if_ready_n  = 1'b0;
    mem_ready_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (mem_elig) begin
          state_n     = BUSY_MEM;
          cnt_n       = LAT_CNT;
          lat_we_n    = bus.mem_we;
          ram_en_n    = 1'b1;
          ram_we_n    = bus.mem_we && (LAT_CNT == '0);
          ram_addr_n  = bus.mem_addr;
          ram_wdata_n = bus.mem_wdata;
        end else if (if_elig) begin
          state_n     = BUSY_IF;
          cnt_n       = LAT_CNT;
          lat_we_n    = 1'b0;
          ram_en_n    = 1'b1;
          ram_addr_n  = bus.if_addr;
          ram_wdata_n = '0;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        if (cnt == '0) begin
          state_n  = IDLE;
          ram_en_n = 1'b0;
          if (state == BUSY_IF) begin
            if_rdata_n = bus.ram_rdata;
            if_ready_n = 1'b1;
          end else begin
            if (!lat_we) mem_rdata_n = bus.ram_rdata;
            mem_ready_n = 1'b1;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
          // Write strobe is registered, so raise it one cycle ahead of cnt==0.
          ram_we_n = lat_we && (cnt == CNT_W'(1));
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pipe_mem_arb.sv
// Scoreboard bench for pipe_mem_arb at LATENCY=2 (u2) and LATENCY=1 (u1).
module tb_pipe_mem_arb;

  logic clk = 1'b0;
  logic rstn2 = 1'b0;
  logic rstn1 = 1'b0;
  always #5 clk = ~clk;

  pipe_mem_arb_if b2 ();
  pipe_mem_arb_if b1 ();

  pipe_mem_arb #(.LATENCY(2)) u2 (.clock(clk), .resetn(rstn2), .bus(b2));
  pipe_mem_arb #(.LATENCY(1)) u1 (.clock(clk), .resetn(rstn1), .bus(b1));

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q_if2[$], q_mem2[$], q_if1[$], q_mem1[$];
  logic [31:0] mrd2 = '0;
  logic [31:0] mrd1 = '0;
  int en_run2 = 0, en_run1 = 0;
  int we_cnt2 = 0, we_cnt1 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ck_port(input string tag, input logic en, input logic we, input logic [31:0] addr,
                         input logic xen, input logic xwe, input logic [31:0] xaddr);
    chk({tag, ".en"}, 32'(en), 32'(xen));
    chk({tag, ".we"}, 32'(we), 32'(xwe));
    if (xen) chk({tag, ".addr"}, addr, xaddr);
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    case (a)
      32'h0040_0000: return 32'h2008_0005;
      32'h0000_0020: return 32'h0000_1234;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Memory model: read data is only valid in the last cycle of the hold window.
  always @(posedge clk) begin
    en_run2 <= b2.ram_en ? en_run2 + 1 : 0;
    en_run1 <= b1.ram_en ? en_run1 + 1 : 0;
  end
  assign b2.ram_rdata = (b2.ram_en && en_run2 == 1) ? data_of(b2.ram_addr) : 32'hBAD0_BAD0;
  assign b1.ram_rdata = (b1.ram_en && en_run1 == 0) ? data_of(b1.ram_addr) : 32'hBAD1_BAD1;

  always @(negedge clk) begin
    if (b2.if_ready === 1'b1) begin
      chk("sb_if2_pending", 32'(q_if2.size() != 0), 32'd1);
      if (q_if2.size() != 0) chk("if2_rdata", b2.if_rdata, q_if2.pop_front());
    end
    if (b2.mem_ready === 1'b1) begin
      chk("sb_mem2_pending", 32'(q_mem2.size() != 0), 32'd1);
      if (q_mem2.size() != 0) chk("mem2_rdata", b2.mem_rdata, q_mem2.pop_front());
    end
    if (b1.if_ready === 1'b1) begin
      chk("sb_if1_pending", 32'(q_if1.size() != 0), 32'd1);
      if (q_if1.size() != 0) chk("if1_rdata", b1.if_rdata, q_if1.pop_front());
    end
    if (b1.mem_ready === 1'b1) begin
      chk("sb_mem1_pending", 32'(q_mem1.size() != 0), 32'd1);
      if (q_mem1.size() != 0) chk("mem1_rdata", b1.mem_rdata, q_mem1.pop_front());
    end
    if (b2.ram_we === 1'b1) begin
      we_cnt2++;
      chk("we2_last_cycle", 32'(en_run2), 32'd1);
    end
    if (b1.ram_we === 1'b1) begin
      we_cnt1++;
      chk("we1_last_cycle", 32'(en_run1), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int we_before;
    b2.if_req = 0; b2.if_addr = '0; b2.mem_req = 0; b2.mem_we = 0; b2.mem_addr = '0; b2.mem_wdata = '0;
    b1.if_req = 0; b1.if_addr = '0; b1.mem_req = 0; b1.mem_we = 0; b1.mem_addr = '0; b1.mem_wdata = '0;
    repeat (3) step();
    chk("rst.en", 32'(b2.ram_en), 0);
    chk("rst.we", 32'(b2.ram_we), 0);
    chk("rst.addr", b2.ram_addr, 0);
    chk("rst.wdata", b2.ram_wdata, 0);
    chk("rst.if_ready", 32'(b2.if_ready), 0);
    chk("rst.mem_ready", 32'(b2.mem_ready), 0);
    chk("rst.if_rdata", b2.if_rdata, 0);
    chk("rst.mem_rdata", b2.mem_rdata, 0);
    chk("rst.stall_if", 32'(b2.stall_if), 0);
    rstn2 = 1; rstn1 = 1;
    step();

    // Single fetch
    b2.if_req = 1; b2.if_addr = 32'h0040_0000; q_if2.push_back(data_of(32'h0040_0000));
    #1 chk("f.c0.stall_if", 32'(b2.stall_if), 1);
    ck_port("f.c0", b2.ram_en, b2.ram_we, b2.ram_addr, 0, 0, 0);
    step(); ck_port("f.c1", b2.ram_en, b2.ram_we, b2.ram_addr, 1, 0, 32'h0040_0000);
    chk("f.c1.stall_if", 32'(b2.stall_if), 1);
    step(); ck_port("f.c2", b2.ram_en, b2.ram_we, b2.ram_addr, 1, 0, 32'h0040_0000);
    chk("f.c2.stall_if", 32'(b2.stall_if), 1);
    step(); ck_port("f.c3", b2.ram_en, b2.ram_we, b2.ram_addr, 0, 0, 0);
    chk("f.c3.if_ready", 32'(b2.if_ready), 1);
    chk("f.c3.stall_if", 32'(b2.stall_if), 0);
    b2.if_req = 0;
    step(); chk("f.c4.if_ready", 32'(b2.if_ready), 0);

    // Store
    b2.mem_req = 1; b2.mem_we = 1; b2.mem_addr = 32'h10; b2.mem_wdata = 32'hDEAD_BEEF;
    q_mem2.push_back(mrd2);
    #1 chk("s.c0.stall_mem", 32'(b2.stall_mem), 1);
    step(); ck_port("s.c1", b2.ram_en, b2.ram_we, b2.ram_addr, 1, 0, 32'h10);
    chk("s.c1.wdata", b2.ram_wdata, 32'hDEAD_BEEF);
    step(); ck_port("s.c2", b2.ram_en, b2.ram_we, b2.ram_addr, 1, 1, 32'h10);
    chk("s.c2.wdata", b2.ram_wdata, 32'hDEAD_BEEF);
    step(); ck_port("s.c3", b2.ram_en, b2.ram_we, b2.ram_addr, 0, 0, 0);
    chk("s.c3.mem_ready", 32'(b2.mem_ready), 1);
    b2.mem_req = 0; b2.mem_we = 0;
    step();

    // Simultaneous requests: MEM load first, then IF
    b2.if_req = 1; b2.if_addr = 32'h0040_0004;
    b2.mem_req = 1; b2.mem_addr = 32'h20;
    mrd2 = data_of(32'h20);
    q_mem2.push_back(mrd2); q_if2.push_back(data_of(32'h0040_0004));
    step(); ck_port("b.c1", b2.ram_en, b2.ram_we, b2.ram_addr, 1, 0, 32'h20);
    step(); ck_port("b.c2", b2.ram_en, b2.ram_we, b2.ram_addr, 1, 0, 32'h20);
    step(); ck_port("b.c3", b2.ram_en, b2.ram_we, b2.ram_addr, 0, 0, 0);
    chk("b.c3.mem_ready", 32'(b2.mem_ready), 1);
    chk("b.c3.stall_if", 32'(b2.stall_if), 1);
    b2.mem_req = 0;
    step(); ck_port("b.c4", b2.ram_en, b2.ram_we, b2.ram_addr, 1, 0, 32'h0040_0004);
    step(); ck_port("b.c5", b2.ram_en, b2.ram_we, b2.ram_addr, 1, 0, 32'h0040_0004);
    step(); chk("b.c6.if_ready", 32'(b2.if_ready), 1);
    b2.if_req = 0;
    step();

    // Continuous fetch; load raised in the IF ready cycle wins that edge
    b2.if_req = 1; b2.if_addr = 32'h100; q_if2.push_back(data_of(32'h100));
    step(); step();
    step(); chk("c.c3.if_ready", 32'(b2.if_ready), 1);
    b2.if_addr = 32'h104; q_if2.push_back(data_of(32'h104));
    b2.mem_req = 1; b2.mem_we = 0; b2.mem_addr = 32'h200;
    mrd2 = data_of(32'h200); q_mem2.push_back(mrd2);
    step(); ck_port("c.c4", b2.ram_en, b2.ram_we, b2.ram_addr, 1, 0, 32'h200);
    step(); ck_port("c.c5", b2.ram_en, b2.ram_we, b2.ram_addr, 1, 0, 32'h200);
    step(); chk("c.c6.mem_ready", 32'(b2.mem_ready), 1);
    chk("c.c6.if_ready", 32'(b2.if_ready), 0);
    b2.mem_req = 0;
    step(); ck_port("c.c7", b2.ram_en, b2.ram_we, b2.ram_addr, 1, 0, 32'h104);
    step(); ck_port("c.c8", b2.ram_en, b2.ram_we, b2.ram_addr, 1, 0, 32'h104);
    step(); chk("c.c9.if_ready", 32'(b2.if_ready), 1);
    b2.if_req = 0;
    step();

    // Store aborted by reset
    we_before = we_cnt2;
    b2.mem_req = 1; b2.mem_we = 1; b2.mem_addr = 32'h30; b2.mem_wdata = 32'h0000_0055;
    step(); ck_port("r.c1", b2.ram_en, b2.ram_we, b2.ram_addr, 1, 0, 32'h30);
    rstn2 = 0; b2.mem_req = 0; b2.mem_we = 0;
    step();
    mrd2 = '0;
    ck_port("r.c2", b2.ram_en, b2.ram_we, b2.ram_addr, 0, 0, 0);
    chk("r.c2.addr", b2.ram_addr, 0);
    chk("r.c2.wdata", b2.ram_wdata, 0);
    chk("r.c2.if_rdata", b2.if_rdata, 0);
    chk("r.c2.mem_rdata", b2.mem_rdata, 0);
    chk("r.c2.mem_ready", 32'(b2.mem_ready), 0);
    rstn2 = 1;
    step(); step();
    chk("r.no_write", 32'(we_cnt2), 32'(we_before));
    b2.if_req = 1; b2.if_addr = 32'h0040_0000; q_if2.push_back(data_of(32'h0040_0000));
    n = 0;
    do begin
      step(); n++;
    end while (b2.if_ready !== 1'b1 && n < 20);
    chk("r.fetch_latency", 32'(n), 32'd3);
    b2.if_req = 0;
    step();

    // LATENCY=1: fetch then store
    b1.if_req = 1; b1.if_addr = 32'h0040_0000; q_if1.push_back(data_of(32'h0040_0000));
    step(); ck_port("l1f.c1", b1.ram_en, b1.ram_we, b1.ram_addr, 1, 0, 32'h0040_0000);
    step(); chk("l1f.c2.if_ready", 32'(b1.if_ready), 1);
    chk("l1f.c2.en", 32'(b1.ram_en), 0);
    b1.if_req = 0;
    step();
    we_before = we_cnt1;
    b1.mem_req = 1; b1.mem_we = 1; b1.mem_addr = 32'h44; b1.mem_wdata = 32'hCAFE_F00D;
    q_mem1.push_back(mrd1);
    step(); ck_port("l1s.c1", b1.ram_en, b1.ram_we, b1.ram_addr, 1, 1, 32'h44);
    chk("l1s.c1.wdata", b1.ram_wdata, 32'hCAFE_F00D);
    step(); chk("l1s.c2.mem_ready", 32'(b1.mem_ready), 1);
    chk("l1s.c2.we", 32'(b1.ram_we), 0);
    b1.mem_req = 0; b1.mem_we = 0;
    step(); step();
    chk("l1s.we_pulses", 32'(we_cnt1 - we_before), 32'd1);

    chk("drain.if2", 32'(q_if2.size()), 0);
    chk("drain.mem2", 32'(q_mem2.size()), 0);
    chk("drain.if1", 32'(q_if1.size()), 0);
    chk("drain.mem1", 32'(q_mem1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
